// File: rtl/dsp_channel_ctrl.sv
// Shadowed configuration sequencer for one DSP channel (phase step, gain, DAC tap).
// Live outputs update together in the cycle after the ce_sample seen while ARMED.
// cfg_ready drops while a commit is pending or applying; writes are held off, never dropped.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   cfg_valid/cfg_ready       host write handshake; cfg_addr selects the shadow, cfg_wdata the value
//   commit                    request a shadow->live transfer on the next sample strobe
//   ce_sample                 decimated sample strobe
//   phase_inc, gain,          live configuration driven to the channel datapath
//   output_select
//   busy                      high whenever a commit or sweep is in progress
//   commit_done               one-cycle pulse in the cycle the new live values first appear
//                             (or the final sweep value appears)
//
// Optional feature: define UBERCLOCK_SWEEP_EN to enable the linear phase sweep
// (addr 3 = signed sweep_step, SWEEP_LEN ce_sample steps after each commit).
module dsp_channel_ctrl #(
    parameter int          PW        = 19,
    parameter logic [31:0] GAIN_RST  = 32'h4000_0000,
    parameter int          SWEEP_LEN = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [1:0]    cfg_addr,
    input  logic [31:0]   cfg_wdata,
    input  logic          commit,
    input  logic          ce_sample,
    output logic [PW-1:0] phase_inc,
    output logic [31:0]   gain,
    output logic [1:0]    output_select,
    output logic          busy,
    output logic          commit_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_APPLY = 2'd2,
        S_SWEEP = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [PW-1:0] sh_phase;
    logic [31:0]   sh_gain;
    logic [1:0]    sh_sel;

    logic          wr_en;
    logic          load_live;
    logic          done_nxt;

    assign cfg_ready = (state == S_IDLE) || (state == S_SWEEP);
    assign busy      = (state != S_IDLE);
    assign wr_en     = cfg_valid && cfg_ready;

`ifdef UBERCLOCK_SWEEP_EN
    localparam int CW = $clog2(SWEEP_LEN + 1);

    logic [PW-1:0] sh_step;     // host-visible sweep_step
    logic [PW-1:0] run_step;    // step captured at APPLY so later writes cannot disturb a running sweep
    logic [CW-1:0] sweep_cnt;
    logic          sweep_tick;
    logic          sweep_start;
`endif

    // ------------------------------------------------------------------
    // Shadow registers. A write in the same IDLE cycle as commit lands here
    // before APPLY, so it is naturally part of that commit.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_phase <= '0;
            sh_gain  <= GAIN_RST;
            sh_sel   <= '0;
`ifdef UBERCLOCK_SWEEP_EN
            sh_step  <= '0;
`endif
        end else if (wr_en) begin
            case (cfg_addr)
                2'd0: sh_phase <= cfg_wdata[PW-1:0];
                2'd1: sh_gain  <= cfg_wdata;
                2'd2: sh_sel   <= cfg_wdata[1:0];
                default: begin
`ifdef UBERCLOCK_SWEEP_EN
                    sh_step <= cfg_wdata[PW-1:0];
`endif
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state. Live registers load on the edge leaving ARMED, so the APPLY
    // cycle is the first cycle showing new values, aligned with commit_done.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        load_live   = 1'b0;
        done_nxt    = 1'b0;
`ifdef UBERCLOCK_SWEEP_EN
        sweep_tick  = 1'b0;
        sweep_start = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                // A coincident ce_sample is deliberately not used: transfer waits for the next one.
                if (commit) state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (ce_sample) begin
                    state_nxt = S_APPLY;
                    load_live = 1'b1;
                    done_nxt  = 1'b1;
                end
            end
            S_APPLY: begin
`ifdef UBERCLOCK_SWEEP_EN
                if (sh_step != '0) begin
                    state_nxt   = S_SWEEP;
                    sweep_start = 1'b1;
                end else begin
                    state_nxt   = S_IDLE;
                end
`else
                state_nxt = S_IDLE;
`endif
            end
            S_SWEEP: begin
`ifdef UBERCLOCK_SWEEP_EN
                // commit aborts the sweep and wins over a coincident sample strobe.
                if (commit) begin
                    state_nxt = S_ARMED;
                end else if (ce_sample) begin
                    sweep_tick = 1'b1;
                    if (sweep_cnt == CW'(1)) begin
                        state_nxt = S_IDLE;
                        done_nxt  = 1'b1;
                    end
                end
`else
                state_nxt = S_IDLE;
`endif
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Live outputs and done pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_inc     <= '0;
            gain          <= GAIN_RST;
            output_select <= '0;
            commit_done   <= 1'b0;
        end else begin
            commit_done <= done_nxt;
            if (load_live) begin
                phase_inc     <= sh_phase;
                gain          <= sh_gain;
                output_select <= sh_sel;
            end
`ifdef UBERCLOCK_SWEEP_EN
            else if (sweep_tick) begin
                // Modulo-2^PW wrap is intended: phase is circular.
                phase_inc <= phase_inc + run_step;
            end
`endif
        end
    end

`ifdef UBERCLOCK_SWEEP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_step  <= '0;
            sweep_cnt <= '0;
        end else begin
            if (sweep_start) begin
                run_step  <= sh_step;
                sweep_cnt <= CW'(SWEEP_LEN);
            end else if (sweep_tick) begin
                sweep_cnt <= sweep_cnt - CW'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_dsp_channel_ctrl.sv
module tb_dsp_channel_ctrl;

    localparam int PW = 19;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_addr;
    logic [31:0]   cfg_wdata;
    logic          commit;
    logic          ce_sample;
    logic [PW-1:0] phase_inc;
    logic [31:0]   gain;
    logic [1:0]    output_select;
    logic          busy;
    logic          commit_done;

    int errors = 0;
    int checks = 0;

    dsp_channel_ctrl #(
        .PW        (PW),
        .GAIN_RST  (32'h4000_0000),
        .SWEEP_LEN (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_addr      (cfg_addr),
        .cfg_wdata     (cfg_wdata),
        .commit        (commit),
        .ce_sample     (ce_sample),
        .phase_inc     (phase_inc),
        .gain          (gain),
        .output_select (output_select),
        .busy          (busy),
        .commit_done   (commit_done)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        cyc();
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        cyc();
        commit = 1'b0;
    endtask

    task automatic pulse_ce();
        ce_sample = 1'b1;
        cyc();
        ce_sample = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        checks++; if (phase_inc !== 19'h0) begin errors++; $display("FAIL reset_phase got=%h exp=%h", phase_inc, 19'h0); end
        checks++; if (gain !== 32'h4000_0000) begin errors++; $display("FAIL reset_gain got=%h exp=%h", gain, 32'h4000_0000); end
        checks++; if (output_select !== 2'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", output_select); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", cfg_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (commit_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", commit_done); end
    endtask

    task automatic test_commit_latency();
        int bad;
        wr(2'd0, 32'h0000_1234);
        wr(2'd1, 32'h2000_0000);
        pulse_commit();
        checks++; if (busy !== 1'b1 || cfg_ready !== 1'b0) begin errors++; $display("FAIL armed_flags got busy=%b ready=%b exp busy=1 ready=0", busy, cfg_ready); end
        bad = 0;
        repeat (9) begin
            cyc();
            if (phase_inc !== 19'h0 || gain !== 32'h4000_0000 || commit_done !== 1'b0) bad++;
        end
        ce_sample = 1'b1;
        #1;
        if (phase_inc !== 19'h0 || gain !== 32'h4000_0000) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL early_update got=%0d bad cycles exp=0", bad); end
        cyc();
        ce_sample = 1'b0;
        checks++; if (phase_inc !== 19'h01234) begin errors++; $display("FAIL live_phase got=%h exp=%h", phase_inc, 19'h01234); end
        checks++; if (gain !== 32'h2000_0000) begin errors++; $display("FAIL live_gain got=%h exp=%h", gain, 32'h2000_0000); end
        checks++; if (commit_done !== 1'b1) begin errors++; $display("FAIL done_pulse got=%b exp=1", commit_done); end
        cyc();
        checks++; if (commit_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL after_apply got done=%b busy=%b exp 0 0", commit_done, busy); end
        checks++; if (phase_inc !== 19'h01234 || gain !== 32'h2000_0000) begin errors++; $display("FAIL hold_live got=%h/%h exp=01234/20000000", phase_inc, gain); end
    endtask

    task automatic test_same_cycle();
        wr(2'd2, 32'd3);
        commit = 1'b1;
        ce_sample = 1'b1;
        cyc();
        commit = 1'b0;
        ce_sample = 1'b0;
        checks++; if (output_select !== 2'd0 || commit_done !== 1'b0) begin errors++; $display("FAIL same_cycle_update got sel=%0d done=%b exp 0 0", output_select, commit_done); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL same_cycle_armed got busy=%b exp=1", busy); end
        cyc();
        pulse_commit();                 // ignored while ARMED
        cyc();
        checks++; if (output_select !== 2'd0) begin errors++; $display("FAIL armed_wait got sel=%0d exp=0", output_select); end
        pulse_ce();
        checks++; if (output_select !== 2'd3 || commit_done !== 1'b1) begin errors++; $display("FAIL next_ce_apply got sel=%0d done=%b exp 3 1", output_select, commit_done); end
        cyc();
        pulse_ce();                     // a queued commit would re-arm and apply here
        checks++; if (busy !== 1'b0 || commit_done !== 1'b0) begin errors++; $display("FAIL no_queue got busy=%b done=%b exp 0 0", busy, commit_done); end
    endtask

    task automatic test_write_armed();
        pulse_commit();
        cfg_valid = 1'b1;
        cfg_addr  = 2'd2;
        cfg_wdata = 32'd1;
        #1;
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL armed_ready got=%b exp=0", cfg_ready); end
        cyc();
        cyc();
        pulse_ce();                     // now APPLY, cfg_valid still held
        checks++; if (output_select !== 2'd3) begin errors++; $display("FAIL armed_write_leak got sel=%0d exp=3", output_select); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL apply_ready got=%b exp=0", cfg_ready); end
        cyc();                          // first IDLE cycle
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got=%b exp=1", cfg_ready); end
        cyc();
        cfg_valid = 1'b0;
        pulse_commit();
        pulse_ce();
        checks++; if (output_select !== 2'd1) begin errors++; $display("FAIL held_write got sel=%0d exp=1", output_select); end
        cyc();
    endtask

`ifdef UBERCLOCK_SWEEP_EN
    task automatic test_sweep();
        logic [PW-1:0] exp_ph [4];
        exp_ph[0] = 19'h7FFFF;
        exp_ph[1] = 19'h00000;
        exp_ph[2] = 19'h00001;
        exp_ph[3] = 19'h00002;
        wr(2'd0, 32'h0007_FFFE);
        wr(2'd3, 32'd1);
        pulse_commit();
        pulse_ce();
        checks++; if (phase_inc !== 19'h7FFFE || commit_done !== 1'b1) begin errors++; $display("FAIL sweep_apply got=%h done=%b exp 7fffe 1", phase_inc, commit_done); end
        cyc();
        checks++; if (busy !== 1'b1 || cfg_ready !== 1'b1) begin errors++; $display("FAIL sweep_state got busy=%b ready=%b exp 1 1", busy, cfg_ready); end
        for (int i = 0; i < 4; i++) begin
            pulse_ce();
            checks++; if (phase_inc !== exp_ph[i]) begin errors++; $display("FAIL sweep_step%0d got=%h exp=%h", i, phase_inc, exp_ph[i]); end
            checks++; if (commit_done !== (i == 3)) begin errors++; $display("FAIL sweep_done%0d got=%b exp=%b", i, commit_done, (i == 3)); end
            cyc();
        end
        checks++; if (busy !== 1'b0 || phase_inc !== 19'h00002) begin errors++; $display("FAIL sweep_end got busy=%b ph=%h exp 0 00002", busy, phase_inc); end
        wr(2'd3, 32'd0);
    endtask
`else
    task automatic test_addr3_discard();
        wr(2'd3, 32'd5);
        pulse_commit();
        pulse_ce();
        checks++; if (commit_done !== 1'b1 || phase_inc !== 19'h01234) begin errors++; $display("FAIL addr3_apply got done=%b ph=%h exp 1 01234", commit_done, phase_inc); end
        cyc();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL addr3_idle got busy=%b exp=0", busy); end
        pulse_ce();
        pulse_ce();
        checks++; if (phase_inc !== 19'h01234 || commit_done !== 1'b0) begin errors++; $display("FAIL addr3_nosweep got ph=%h done=%b exp 01234 0", phase_inc, commit_done); end
    endtask
`endif

    task automatic test_reset_mid();
        wr(2'd0, 32'h0000_0555);
        pulse_commit();
        rst = 1'b1;
        #1;
        checks++; if (phase_inc === 19'h0 && gain === 32'h4000_0000 && output_select === 2'd0 && busy === 1'b0 && cfg_ready === 1'b1) ; else begin
            errors++; $display("FAIL mid_reset got ph=%h g=%h sel=%0d busy=%b rdy=%b exp 0 40000000 0 0 1", phase_inc, gain, output_select, busy, cfg_ready);
        end
        cyc();
        rst = 1'b0;
        cyc();
        pulse_ce();
        checks++; if (busy !== 1'b0 || commit_done !== 1'b0 || phase_inc !== 19'h0) begin errors++; $display("FAIL discarded_commit got busy=%b done=%b ph=%h exp 0 0 0", busy, commit_done, phase_inc); end
    endtask

    initial begin
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_addr  = 2'd0;
        cfg_wdata = 32'd0;
        commit    = 1'b0;
        ce_sample = 1'b0;
        test_reset();
        test_commit_latency();
        test_same_cycle();
        test_write_armed();
`ifdef UBERCLOCK_SWEEP_EN
        test_sweep();
`else
        test_addr3_discard();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
